// File: rtl/capture_ctrl.sv
// Run-control sequencer for the capture sample-packing cache: arms, configures,
// gates the cache through pre/post-trigger and counts packed words.
module capture_ctrl #(
    parameter int INPUT = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [INPUT-1:0] grp_dis_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic             trg_i,
    input  logic             smpl_stb_i,
    input  logic             word_stb_i,
    output logic             cache_cfg_stb_o,
    output logic [INPUT-1:0] cache_cfg_o,
    output logic             cache_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    logic [INPUT-1:0] r_mask;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_words;
    logic             r_err;

    logic w_capturing;
    logic w_mask_bad;
    logic w_last_smpl;

    assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_mask_bad  = &grp_dis_i;
    // r_delay is never zero while in POST, so delay-1 cannot underflow here.
    assign w_last_smpl = smpl_stb_i && (r_dcnt == r_delay - ONE);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_delay <= '0;
            r_dcnt  <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // Word strobes belong to the state they arrive in, even on the exit cycle.
            if (w_capturing && word_stb_i && !(&r_words))
                r_words <= r_words + ONE;

            if (abort_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (arm_i) begin
                            if (w_mask_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_mask  <= grp_dis_i;
                                r_delay <= delay_i;
                                r_dcnt  <= '0;
                                r_words <= '0;
                                r_state <= S_CFG;
                            end
                        end
                    end
                    S_CFG: r_state <= S_ARMED;
                    S_ARMED: begin
                        if (trg_i) begin
                            r_dcnt  <= '0;
                            r_state <= (r_delay == '0) ? S_DONE : S_POST;
                        end
                    end
                    S_POST: begin
                        if (smpl_stb_i) begin
                            r_dcnt <= r_dcnt + ONE;
                            if (w_last_smpl)
                                r_state <= S_DONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cache_cfg_stb_o = (r_state == S_CFG);
    assign cache_cfg_o     = r_mask;
    assign cache_en_o      = w_capturing;
    assign busy_o          = (r_state == S_CFG) || w_capturing;
    assign done_o          = (r_state == S_DONE);
    assign err_o           = r_err;
    assign words_o         = r_words;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: a phase/countdown model checked every cycle
// against two instances (CNT_W=16 and CNT_W=4), plus hand-computed spot checks.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  grp_dis = 4'b0000;
    logic [15:0] delay = 16'd0;
    logic        trg = 1'b0;
    logic        smpl = 1'b0;
    logic        word = 1'b0;

    logic        cfg_stb, en, busy, done, err;
    logic [3:0]  cfg;
    logic [15:0] words;
    logic        cfg_stb4, en4, busy4, done4, err4;
    logic [3:0]  cfg4;
    logic [3:0]  words4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    capture_ctrl #(.INPUT(4), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .abort_i(abort),
        .grp_dis_i(grp_dis), .delay_i(delay), .trg_i(trg),
        .smpl_stb_i(smpl), .word_stb_i(word),
        .cache_cfg_stb_o(cfg_stb), .cache_cfg_o(cfg), .cache_en_o(en),
        .busy_o(busy), .done_o(done), .err_o(err), .words_o(words)
    );

    capture_ctrl #(.INPUT(4), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .abort_i(abort),
        .grp_dis_i(grp_dis), .delay_i(delay[3:0]), .trg_i(trg),
        .smpl_stb_i(smpl), .word_stb_i(word),
        .cache_cfg_stb_o(cfg_stb4), .cache_cfg_o(cfg4), .cache_en_o(en4),
        .busy_o(busy4), .done_o(done4), .err_o(err4), .words_o(words4)
    );

    // Model: phase of the capture, remaining post-trigger samples, unbounded word count.
    localparam int P_IDLE = 0, P_CFG = 1, P_ARMED = 2, P_POST = 3, P_DONE = 4;
    int       m_phase = P_IDLE;
    logic [3:0] m_mask = 4'b0000;
    int       m_delay = 0;
    int       m_left  = 0;
    int       m_words = 0;
    logic     m_err   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_mask = 4'b0000; m_delay = 0;
            m_left = 0; m_words = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if ((m_phase == P_ARMED || m_phase == P_POST) && word)
                m_words = m_words + 1;
            if (abort) begin
                m_phase = P_IDLE;
            end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
                if (arm && grp_dis == 4'b1111) begin
                    m_err = 1'b1;
                end else if (arm) begin
                    m_mask = grp_dis; m_delay = int'(delay); m_words = 0; m_phase = P_CFG;
                end
            end else if (m_phase == P_CFG) begin
                m_phase = P_ARMED;
            end else if (m_phase == P_ARMED && trg) begin
                m_left  = m_delay;
                m_phase = (m_delay == 0) ? P_DONE : P_POST;
            end else if (m_phase == P_POST && smpl) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = P_DONE;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_en, exp_busy;
        int w16, w4;
        exp_en   = (m_phase == P_ARMED || m_phase == P_POST);
        exp_busy = exp_en || (m_phase == P_CFG);
        w16 = (m_words > 65535) ? 65535 : m_words;
        w4  = (m_words > 15) ? 15 : m_words;
        check("cfg_stb", 32'(cfg_stb), 32'(m_phase == P_CFG));
        check("cfg",     32'(cfg),     32'(m_mask));
        check("en",      32'(en),      32'(exp_en));
        check("busy",    32'(busy),    32'(exp_busy));
        check("done",    32'(done),    32'(m_phase == P_DONE));
        check("err",     32'(err),     32'(m_err));
        check("words",   32'(words),   32'(w16));
        check("en4",     32'(en4),     32'(exp_en));
        check("done4",   32'(done4),   32'(m_phase == P_DONE));
        check("err4",    32'(err4),    32'(m_err));
        check("cfg_stb4", 32'(cfg_stb4), 32'(m_phase == P_CFG));
        check("busy4",   32'(busy4),   32'(exp_busy));
        check("cfg4",    32'(cfg4),    32'(m_mask));
        check("words4",  32'(words4),  32'(w4));
    endtask

    always @(negedge clk) compare_all();

    task automatic step(input logic a, input logic ab, input logic t, input logic s, input logic w);
        arm = a; abort = ab; trg = t; smpl = s; word = w;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_en", 32'(en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words", 32'(words), 32'd0);
        rst = 1'b0;

        // Arm with mask 0011, delay 3.
        grp_dis = 4'b0011; delay = 16'd3;
        step(1, 0, 0, 0, 0);
        check("t1_cfg_stb", 32'(cfg_stb), 32'd1);
        check("t1_cfg", 32'(cfg), 32'h3);
        check("t1_en_cfg", 32'(en), 32'd0);
        step(0, 0, 0, 0, 0);
        check("t1_en_armed", 32'(en), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);

        // Trigger (with a word), then samples; third sample ends capture.
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t2_en_after2", 32'(en), 32'd1);
        step(0, 0, 0, 1, 1);
        check("t2_en_fall", 32'(en), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_words", 32'(words), 32'd2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("t2_hold", 32'(done), 32'd1);

        // Rearm from DONE with delay 0: trigger goes straight to DONE.
        delay = 16'd0;
        step(1, 0, 0, 0, 0);
        check("t3_words_clr", 32'(words), 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_en", 32'(en), 32'd0);

        // Abort to IDLE, then rejected arm.
        step(0, 1, 0, 0, 0);
        grp_dis = 4'b1111;
        step(1, 0, 0, 0, 0);
        check("t4_err", 32'(err), 32'd1);
        check("t4_cfg_stb", 32'(cfg_stb), 32'd0);
        check("t4_cfg_kept", 32'(cfg), 32'h3);
        check("t4_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 0, 0);
        check("t4_err_pulse", 32'(err), 32'd0);

        // Four words, then abort together with trigger.
        grp_dis = 4'b0101; delay = 16'd5;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_words", 32'(words), 32'd4);

        // Saturation on the narrow instance; arm ignored while armed.
        grp_dis = 4'b0000; delay = 16'd3;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
        check("t6_words16", 32'(words), 32'd20);
        check("t6_words4", 32'(words4), 32'd15);
        grp_dis = 4'b1111;
        step(1, 0, 0, 0, 0);
        check("t6_arm_ign_err", 32'(err), 32'd0);
        check("t6_arm_ign_cfg", 32'(cfg), 32'h0);
        check("t6_arm_ign_en", 32'(en), 32'd1);
        grp_dis = 4'b0000;

        // Async reset in the middle of POST.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("t7_in_post", 32'(en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_en", 32'(en), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_words", 32'(words), 32'd0);
        check("t7_cfg_stb", 32'(cfg_stb), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 1, 1);
        check("t7_idle", 32'(busy), 32'd0);
        check("t7_trg_ign", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Run-control sequencer for the sample-packing cache in the logic-analyzer capture path.
- Arms a capture, pushes the channel-group configuration into the cache, and gates the cache enable through the pre-trigger and post-trigger phases.
- Stops capture after a programmed post-trigger sample count, then reports completion and the number of packed words written to memory.
- Sits between the host command decoder (arm/abort/config), the trigger stage (trg_i) and the cache.

Parameters:
- INPUT, 4, number of input byte groups (matches the cache INPUT).
- CNT_W, 16, width of the delay counter and word counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active high
- arm_i  in  1  host arm pulse
- abort_i  in  1  host abort pulse
- grp_dis_i  in  INPUT  group disable mask; 1 = group unused
- delay_i  in  CNT_W  post-trigger sample count
- trg_i  in  1  trigger hit from trigger stage
- smpl_stb_i  in  1  new sample valid (same strobe fed to cache stb_i)
- word_stb_i  in  1  cache stb_o: packed word produced
- cache_cfg_stb_o  out  1  to cache cfg_stb_i
- cache_cfg_o  out  INPUT  to cache cfg_i
- cache_en_o  out  1  to cache en_i
- busy_o  out  1  capture in progress
- done_o  out  1  capture complete
- err_o  out  1  one-cycle pulse: arm rejected
- words_o  out  CNT_W  packed words produced in current capture

Behaviour:
- Reset (async, rst_i=1): state=IDLE; all outputs 0; latched mask, delay, counters = 0.
- States: IDLE, CFG, ARMED, POST, DONE. State is registered; cache_en_o, busy_o and done_o decode combinationally from the state register.
- Priority every cycle: abort_i > arm_i > trg_i/smpl_stb_i.
- abort_i=1 in any state: next state IDLE. Counters keep their values, so words_o stays readable.
- IDLE, arm_i=1:
  - grp_dis_i all ones: stay IDLE, err_o=1 for one cycle, latches unchanged.
  - Otherwise latch grp_dis_i and delay_i, clear words_o and the delay count, go CFG.
- CFG (exactly 1 cycle): cache_cfg_stb_o=1, cache_cfg_o=latched mask. Next state ARMED.
- cache_cfg_o holds the latched mask in all states.
- ARMED: cache_en_o=1.
  - trg_i=1: if latched delay=0, go DONE; else go POST with delay count=0.
  - trg_i is ignored in IDLE, CFG, POST and DONE.
- POST: cache_en_o=1; each smpl_stb_i increments the delay count.
  - When smpl_stb_i=1 and delay count = delay-1: go DONE.
  - That final sample is still captured, because cache_en_o is high in that cycle.
  - Exactly `delay` post-trigger samples are enabled.
- DONE: cache_en_o=0, done_o=1; hold until arm_i (rearm, same rules as in IDLE, including err_o) or abort_i (to IDLE).
- busy_o=1 in CFG, ARMED and POST.
- words_o:
  - Increments on word_stb_i while in ARMED or POST.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset or an accepted arm.
- arm_i in CFG/ARMED/POST is ignored (no re-latch, no err_o).
- Latency: arm_i to cache_cfg_stb_o = 1 cycle; arm_i to cache_en_o = 2 cycles; qualifying sample to done_o = 1 cycle.
- Simultaneous trg_i and abort_i: abort wins.
- word_stb_i in the same cycle as the state change to DONE: counted, since it is attributed to the current state.

Test Plan:
- Reset then arm_i with grp_dis_i=4'b0011, delay_i=3 -> cache_cfg_stb_o pulses 1 cycle later with cache_cfg_o=0011; cache_en_o=1 from the next cycle; busy_o=1.
- Armed, trg_i=1, then 5 smpl_stb_i pulses -> cache_en_o falls after the 3rd sample; done_o=1 and busy_o=0 from the following cycle.
- delay_i=0, trg_i in ARMED -> DONE next cycle; no POST state.
- arm_i with grp_dis_i=4'b1111 -> err_o single-cycle pulse; state stays IDLE; no cache_cfg_stb_o.
- Armed, 4 word_stb_i pulses, abort_i together with trg_i -> IDLE next cycle; words_o=4; done_o=0.
- CNT_W=4, 20 word_stb_i pulses in ARMED -> words_o saturates at 15.
- Assert rst_i asynchronously during POST -> all outputs 0 immediately; state IDLE.
